// File: rtl/ymem_pkg.sv
// ---------------------------------------------------------------------------
// ymem_pkg
// Shared definitions for the yMem write-back path.
//   - Row layout constants: 4 slots of 64 bits, each slot is a 16-bit tag
//     followed by a 48-bit value {real[23:0], imag[23:0]}.
//   - Default tag prefix that marks the diagonal slot.
//   - Write-back FSM state encoding.
//   - slotMsb(): bit index of the top of slot k inside a row.
// ---------------------------------------------------------------------------
package ymem_pkg;

  localparam int SLOT_W = 64;
  localparam int TAG_W  = 16;
  localparam int VAL_W  = 48;
  localparam int HALF_W = 24;
  localparam int SLOT_N = 4;
  localparam int ROW_W  = SLOT_N * SLOT_W;

  localparam logic [2:0] DIAG_FLAG_DEF = 3'b111;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD,
    ST_RWAIT,
    ST_MOD,
    ST_WR,
    ST_NEXT,
    ST_DONE
  } wbState_e;

  // Slot 0 sits in the most significant 64 bits of the row.
  function automatic int slotMsb(input int k);
    return ROW_W - 1 - SLOT_W * k;
  endfunction

endpackage

// File: rtl/ymem_slot_merge.sv
// ---------------------------------------------------------------------------
// ymem_slot_merge
// Combinational slot lookup and value merge for one yMem row.
//   row_i       : 256-bit row as read from yMem
//   matchCol_i  : column whose tag is searched for (off-diagonal case)
//   diagSel_i   : 1 = look for the diagonal tag prefix instead of a full tag
//   newVal_i    : incoming {real, imag} value
//   merged_o    : row with only the selected value field updated
//   hit_o       : a matching slot exists
// ACCUM selects replace (0) or per-half modulo add (1).
// ---------------------------------------------------------------------------
module ymem_slot_merge
  import ymem_pkg::*;
#(
  parameter bit         ACCUM     = 1'b0,
  parameter logic [2:0] DIAG_FLAG = DIAG_FLAG_DEF
) (
  input  logic [ROW_W-1:0] row_i,
  input  logic [TAG_W-1:0] matchCol_i,
  input  logic             diagSel_i,
  input  logic [VAL_W-1:0] newVal_i,
  output logic [ROW_W-1:0] merged_o,
  output logic             hit_o
);

  logic [TAG_W-1:0] curTag;
  logic [VAL_W-1:0] oldVal;
  logic [VAL_W-1:0] mergedVal;
  int               selIdx;
  int               valMsb;

  // Scan the slots from highest index down so that the last hit recorded
  // is the lowest index, which is the one that must win.
  always_comb begin
    hit_o  = 1'b0;
    selIdx = 0;
    curTag = '0;
    for (int k = SLOT_N - 1; k >= 0; k--) begin
      curTag = row_i[slotMsb(k) -: TAG_W];
      if (diagSel_i ? (curTag[TAG_W-1 -: 3] == DIAG_FLAG) : (curTag == matchCol_i)) begin
        hit_o  = 1'b1;
        selIdx = k;
      end
    end
  end

  // Build the output row: everything passes through except the value field
  // of the selected slot. In accumulate mode real and imag wrap separately,
  // so the two halves are added as independent 24-bit quantities.
  always_comb begin
    valMsb = slotMsb(selIdx) - TAG_W;
    oldVal = row_i[valMsb -: VAL_W];
    if (ACCUM) begin
      mergedVal = {oldVal[VAL_W-1 -: HALF_W] + newVal_i[VAL_W-1 -: HALF_W],
                   oldVal[HALF_W-1:0]        + newVal_i[HALF_W-1:0]};
    end else begin
      mergedVal = newVal_i;
    end
    merged_o = row_i;
    if (hit_o) begin
      merged_o[valMsb -: VAL_W] = mergedVal;
    end
  end

endmodule

// File: rtl/ymem_wb.sv
// ---------------------------------------------------------------------------
// ymem_wb
// Write-back of calc_y results into yMem by read-modify-write of whole rows.
// A request (row, col) updates element (row, col) and, when off-diagonal,
// the mirror element (col, row) in a second phase.
//   clock, reset          : clock and asynchronous active-high reset
//   wb_EN/row/col/yVal    : request, sampled only when idle
//   ymem_rdata, dataReady : row read data and its valid strobe
//   wr_Ack                : memory accepted the write
//   op_y_row              : row address of the current phase
//   op_rd_EN              : one-cycle read request
//   op_wr_EN, op_wdata    : write request, held until wr_Ack
//   op_Busy, op_Done      : not idle / one-cycle completion pulse
//   op_Miss               : sticky, some phase found no matching slot
// ---------------------------------------------------------------------------
module ymem_wb
  import ymem_pkg::*;
#(
  parameter bit         ACCUM     = 1'b0,
  parameter logic [2:0] DIAG_FLAG = DIAG_FLAG_DEF
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             wb_EN,
  input  logic [TAG_W-1:0] wb_row,
  input  logic [TAG_W-1:0] wb_col,
  input  logic [VAL_W-1:0] wb_yVal,
  input  logic [ROW_W-1:0] ymem_rdata,
  input  logic             dataReady,
  input  logic             wr_Ack,
  output logic [TAG_W-1:0] op_y_row,
  output logic             op_rd_EN,
  output logic             op_wr_EN,
  output logic [ROW_W-1:0] op_wdata,
  output logic             op_Busy,
  output logic             op_Done,
  output logic             op_Miss
);

  wbState_e         state_q, state_d;
  logic [TAG_W-1:0] row_q, col_q;
  logic [VAL_W-1:0] yVal_q;
  logic [ROW_W-1:0] rdata_q, wdata_q;
  logic             phaseB_q, miss_q;

  logic [TAG_W-1:0] phaseRow, phaseCol;
  logic             needPhaseB;
  logic [ROW_W-1:0] merged;
  logic             hit;

  // Phase B is the mirror access, so row and column simply swap roles.
  assign phaseRow   = phaseB_q ? col_q : row_q;
  assign phaseCol   = phaseB_q ? row_q : col_q;
  assign needPhaseB = !phaseB_q && (row_q != col_q);

  ymem_slot_merge #(
    .ACCUM     (ACCUM),
    .DIAG_FLAG (DIAG_FLAG)
  ) u_merge (
    .row_i      (rdata_q),
    .matchCol_i (phaseCol),
    .diagSel_i  (phaseRow == phaseCol),
    .newVal_i   (yVal_q),
    .merged_o   (merged),
    .hit_o      (hit)
  );

  // State register; reset forces IDLE at once, which also kills any
  // write request in flight since op_wr_EN decodes straight from state.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic. Handshake inputs only matter in the state that waits
  // on them, so stray strobes elsewhere fall through harmlessly.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (wb_EN) state_d = ST_RD;
      ST_RD:    state_d = ST_RWAIT;
      ST_RWAIT: if (dataReady) state_d = ST_MOD;
      ST_MOD:   state_d = hit ? ST_WR : ST_NEXT;
      ST_WR:    if (wr_Ack) state_d = ST_NEXT;
      ST_NEXT:  state_d = needPhaseB ? ST_RD : ST_DONE;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Request/phase bookkeeping, captured read row and the write row built
  // in MOD. The miss flag is cleared only when a new request is accepted.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      row_q    <= '0;
      col_q    <= '0;
      yVal_q   <= '0;
      rdata_q  <= '0;
      wdata_q  <= '0;
      phaseB_q <= 1'b0;
      miss_q   <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (wb_EN) begin
            row_q    <= wb_row;
            col_q    <= wb_col;
            yVal_q   <= wb_yVal;
            phaseB_q <= 1'b0;
            miss_q   <= 1'b0;
          end
        end
        ST_RWAIT: begin
          if (dataReady) rdata_q <= ymem_rdata;
        end
        ST_MOD: begin
          if (hit) wdata_q <= merged;
          else     miss_q  <= 1'b1;
        end
        ST_NEXT: begin
          if (needPhaseB) phaseB_q <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Outputs are pure decodes of the state plus held registers.
  always_comb begin
    op_y_row = phaseRow;
    op_rd_EN = (state_q == ST_RD);
    op_wr_EN = (state_q == ST_WR);
    op_wdata = wdata_q;
    op_Busy  = (state_q != ST_IDLE);
    op_Done  = (state_q == ST_DONE);
    op_Miss  = miss_q;
  end

endmodule

// File: tb/tb_ymem_wb.sv
// ---------------------------------------------------------------------------
// tb_ymem_wb
// Drives two ymem_wb instances (replace and accumulate) with the same
// request and memory responses and compares each against a behavioural
// row-merge model and the expected handshake timing.
// ---------------------------------------------------------------------------
module tb_ymem_wb;

  logic         clock = 1'b0;
  logic         reset = 1'b1;
  logic         wb_EN = 1'b0;
  logic [15:0]  wb_row = '0;
  logic [15:0]  wb_col = '0;
  logic [47:0]  wb_yVal = '0;
  logic [255:0] ymem_rdata = '0;
  logic         dataReady = 1'b0;
  logic         wr_Ack = 1'b0;

  logic [15:0]  yRow0, yRow1;
  logic         rdEn0, rdEn1, wrEn0, wrEn1;
  logic [255:0] wdata0, wdata1;
  logic         busy0, busy1, done0, done1, miss0, miss1;

  int checkCount = 0;
  int errorCount = 0;
  int rdPulses = 0;
  int wrCycles = 0;
  logic [255:0] lastW0 [2];
  logic [255:0] lastW1 [2];

  ymem_wb #(.ACCUM(1'b0)) dut0 (
    .clock(clock), .reset(reset), .wb_EN(wb_EN), .wb_row(wb_row), .wb_col(wb_col),
    .wb_yVal(wb_yVal), .ymem_rdata(ymem_rdata), .dataReady(dataReady), .wr_Ack(wr_Ack),
    .op_y_row(yRow0), .op_rd_EN(rdEn0), .op_wr_EN(wrEn0), .op_wdata(wdata0),
    .op_Busy(busy0), .op_Done(done0), .op_Miss(miss0)
  );

  ymem_wb #(.ACCUM(1'b1)) dut1 (
    .clock(clock), .reset(reset), .wb_EN(wb_EN), .wb_row(wb_row), .wb_col(wb_col),
    .wb_yVal(wb_yVal), .ymem_rdata(ymem_rdata), .dataReady(dataReady), .wr_Ack(wr_Ack),
    .op_y_row(yRow1), .op_rd_EN(rdEn1), .op_wr_EN(wrEn1), .op_wdata(wdata1),
    .op_Busy(busy1), .op_Done(done1), .op_Miss(miss1)
  );

  // Free-running clock, rising edges at 5, 15, 25 ...
  always #5 clock = ~clock;

  // Activity counters sampled mid-cycle, used to count reads and write cycles.
  always @(negedge clock) begin
    if (rdEn0) rdPulses++;
    if (wrEn0) wrCycles++;
  end

  task automatic checkOutput(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checkCount++;
    if (obs !== exp) begin
      errorCount++;
      $display("[TB] FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Random row; mode 0 = one matching slot, 1 = none, 2 = up to two matches.
  function automatic logic [255:0] makeRow(input logic [15:0] tcol, input bit diag, input int mode);
    logic [255:0] rowv;
    logic [15:0]  tag;
    logic [47:0]  val;
    int k1, k2;
    rowv = '0;
    for (int k = 0; k < 4; k++) begin
      tag = 16'($urandom);
      val = {16'($urandom), 32'($urandom)};
      if (diag && tag[15:13] == 3'b111) tag[15] = 1'b0;
      if (!diag && tag == tcol) tag = ~tcol;
      rowv[255-64*k -: 64] = {tag, val};
    end
    if (mode != 1) begin
      k1 = $urandom_range(0, 3);
      rowv[255-64*k1 -: 16] = diag ? {3'b111, 13'($urandom)} : tcol;
      if (mode == 2) begin
        k2 = $urandom_range(0, 3);
        rowv[255-64*k2 -: 16] = diag ? {3'b111, 13'($urandom)} : tcol;
      end
    end
    return rowv;
  endfunction

  // Reference: unpack row into tag/value arrays, pick first matching slot,
  // update its value, repack.
  function automatic logic [255:0] modelMerge(input logic [255:0] rowData, input logic [15:0] mCol,
                                             input bit diag, input logic [47:0] yv, input bit accum,
                                             output bit hit);
    logic [15:0]  tags [4];
    logic [47:0]  vals [4];
    logic [255:0] res;
    logic [23:0]  re, im;
    int target;
    target = -1;
    for (int k = 0; k < 4; k++) {tags[k], vals[k]} = rowData[255-64*k -: 64];
    for (int k = 0; k < 4; k++) begin
      if (target < 0 && (diag ? (tags[k][15:13] == 3'b111) : (tags[k] == mCol))) target = k;
    end
    hit = (target >= 0);
    if (hit) begin
      if (accum) begin
        re = vals[target][47:24] + yv[47:24];
        im = vals[target][23:0] + yv[23:0];
        vals[target] = {re, im};
      end else begin
        vals[target] = yv;
      end
    end
    res = '0;
    for (int k = 0; k < 4; k++) res[255-64*k -: 64] = {tags[k], vals[k]};
    return res;
  endfunction

  // One complete request, playing the memory side with the given delays.
  task automatic applyStimulus(input logic [15:0] r, input logic [15:0] c, input logic [47:0] yv,
                               input logic [255:0] rowA, input logic [255:0] rowB,
                               input int rdDelay, input int ackDelay, input bit earlyReady);
    int phases;
    logic [15:0]  pr, pc;
    logic [255:0] rd, exp0, exp1;
    bit hit0, hit1, expMiss;
    phases  = (r == c) ? 1 : 2;
    expMiss = 1'b0;
    wb_row = r; wb_col = c; wb_yVal = yv; wb_EN = 1'b1;
    @(negedge clock);
    wb_EN = 1'b0;
    for (int p = 0; p < phases; p++) begin
      pr = (p == 0) ? r : c;
      pc = (p == 0) ? c : r;
      rd = (p == 0) ? rowA : rowB;
      exp0 = modelMerge(rd, pc, pr == pc, yv, 1'b0, hit0);
      exp1 = modelMerge(rd, pc, pr == pc, yv, 1'b1, hit1);
      checkOutput("rdEn", {rdEn0, rdEn1}, 2'b11);
      checkOutput("rdRow", {yRow0, yRow1}, {pr, pr});
      checkOutput("busy", {busy0, busy1}, 2'b11);
      if (p == 0) checkOutput("missClear", {miss0, miss1}, 2'b00);
      dataReady = earlyReady; ymem_rdata = ~rd;
      @(negedge clock);
      checkOutput("rdPulse", {rdEn0, rdEn1}, 2'b00);
      for (int i = 0; i < rdDelay; i++) begin
        dataReady = 1'b0; wb_EN = 1'b1;
        wb_row = 16'($urandom); wb_col = 16'($urandom);
        wr_Ack = 1'($urandom_range(0, 1));
        @(negedge clock);
        checkOutput("rdHold", {yRow0, yRow1, rdEn0, rdEn1, wrEn0, wrEn1}, {pr, pr, 4'b0000});
      end
      wb_EN = 1'b0; wr_Ack = 1'b0; dataReady = 1'b1; ymem_rdata = rd;
      @(negedge clock);
      dataReady = 1'b0; ymem_rdata = ~rd;
      checkOutput("modNoWr", {wrEn0, wrEn1}, 2'b00);
      @(negedge clock);
      checkOutput("wrEn", {wrEn0, wrEn1}, {hit0, hit1});
      if (hit0) begin
        checkOutput("wdata0", wdata0, exp0);
        checkOutput("wdata1", wdata1, exp1);
        checkOutput("wrRow", {yRow0, yRow1}, {pr, pr});
        lastW0[p] = wdata0;
        lastW1[p] = wdata1;
        for (int i = 0; i < ackDelay; i++) begin
          wr_Ack = 1'b0; dataReady = 1'($urandom_range(0, 1));
          @(negedge clock);
          checkOutput("wrHold", {wrEn0, wrEn1, yRow0, yRow1}, {2'b11, pr, pr});
          checkOutput("wdHold0", wdata0, exp0);
          checkOutput("wdHold1", wdata1, exp1);
        end
        dataReady = 1'b0; wr_Ack = 1'b1;
        @(negedge clock);
        wr_Ack = 1'b0;
        checkOutput("wrDrop", {wrEn0, wrEn1}, 2'b00);
      end else begin
        expMiss = 1'b1;
        lastW0[p] = '0;
        lastW1[p] = '0;
      end
      checkOutput("nextNoDone", {done0, done1, busy0, busy1}, 4'b0011);
      @(negedge clock);
    end
    checkOutput("done", {done0, done1}, 2'b11);
    checkOutput("missDone", {miss0, miss1}, {expMiss, expMiss});
    @(negedge clock);
    checkOutput("idle", {done0, done1, busy0, busy1, miss0, miss1}, {4'b0000, expMiss, expMiss});
  endtask

  // Start an off-diagonal request and pull reset while the write is pending.
  task automatic resetMidWrite();
    logic [255:0] rowA;
    rowA = makeRow(16'd3, 1'b0, 0);
    wb_row = 16'd2; wb_col = 16'd3; wb_yVal = 48'h1; wb_EN = 1'b1;
    @(negedge clock);
    wb_EN = 1'b0;
    @(negedge clock);
    dataReady = 1'b1; ymem_rdata = rowA;
    @(negedge clock);
    dataReady = 1'b0;
    @(negedge clock);
    checkOutput("preRstWr", {wrEn0, wrEn1}, 2'b11);
    #2 reset = 1'b1;
    #1;
    checkOutput("rstWrDrop", {wrEn0, wrEn1, busy0, busy1, done0, done1}, 6'b000000);
    @(negedge clock);
    reset = 1'b0; wr_Ack = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      checkOutput("rstNoDone", {done0, done1, busy0, busy1, wrEn0, wrEn1}, 6'b000000);
    end
    wr_Ack = 1'b0;
  endtask

  initial begin
    logic [255:0] rowA, rowB, expRow;
    logic [15:0]  r, c;
    int modeA, modeB;

    repeat (2) @(negedge clock);
    checkOutput("rstCtl", {rdEn0, wrEn0, busy0, done0, miss0, yRow0, rdEn1, wrEn1, busy1, done1, miss1, yRow1}, '0);
    checkOutput("rstWdata", wdata0 | wdata1, '0);
    reset = 1'b0;
    @(negedge clock);

    // Off-diagonal replace with a known slot layout.
    rowA = makeRow(16'd9, 1'b0, 1);
    rowA[255-64 -: 64] = {16'h0009, 48'h000100000200};
    rowB = makeRow(16'd5, 1'b0, 1);
    rowB[255-128 -: 64] = {16'h0005, 48'h0};
    rdPulses = 0; wrCycles = 0;
    applyStimulus(16'd5, 16'd9, 48'h000010000020, rowA, rowB, 0, 0, 1'b0);
    expRow = rowA;
    expRow[255-64-16 -: 48] = 48'h000010000020;
    checkOutput("replaceRow", lastW0[0], expRow);
    checkOutput("accumSlot1", lastW1[0][255-64-16 -: 48], 48'h000110000220);
    checkOutput("phaseBSlot2", lastW0[1][255-128-16 -: 48], 48'h000010000020);
    checkOutput("offDiagCounts", {rdPulses[7:0], wrCycles[7:0]}, {8'd2, 8'd2});

    // Diagonal request, also covering accumulate wrap on each half.
    rowA = makeRow(16'd7, 1'b1, 1);
    rowA[255 -: 64] = {16'hE007, 48'h7FFFFF000001};
    rdPulses = 0; wrCycles = 0;
    applyStimulus(16'd7, 16'd7, 48'h000001FFFFFF, rowA, rowA, 0, 0, 1'b1);
    checkOutput("diagReplace", lastW0[0][239 -: 48], 48'h000001FFFFFF);
    checkOutput("accumWrap", lastW1[0][239 -: 48], 48'h800000000000);
    checkOutput("diagCounts", {rdPulses[7:0], wrCycles[7:0]}, {8'd1, 8'd1});

    // Phase A miss, phase B still runs; miss then cleared by next request.
    rowA = makeRow(16'd12, 1'b0, 1);
    rowB = makeRow(16'd4, 1'b0, 0);
    wrCycles = 0;
    applyStimulus(16'd4, 16'd12, 48'hABCDEF123456, rowA, rowB, 1, 1, 1'b0);
    checkOutput("missSticky", {miss0, miss1}, 2'b11);
    checkOutput("missWrCycles", wrCycles, 2);

    // Long stalls on both handshakes.
    rowA = makeRow(16'd2, 1'b0, 0);
    rowB = makeRow(16'd1, 1'b0, 0);
    wrCycles = 0;
    applyStimulus(16'd1, 16'd2, 48'h123456654321, rowA, rowB, 5, 3, 1'b1);
    checkOutput("stallWrCycles", wrCycles, 8);

    resetMidWrite();

    // Randomized traffic.
    for (int n = 0; n < 40; n++) begin
      r = 16'($urandom_range(0, 7));
      c = ($urandom_range(0, 3) == 0) ? r : 16'($urandom_range(0, 7));
      modeA = $urandom_range(0, 2);
      modeB = $urandom_range(0, 2);
      rowA = makeRow(c, r == c, modeA);
      rowB = makeRow(r, 1'b0, modeB);
      applyStimulus(r, c, {16'($urandom), 32'($urandom)}, rowA, rowB,
                    $urandom_range(0, 3), $urandom_range(0, 2), 1'($urandom_range(0, 1)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule
